sram_bus_arbiter: RTL

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_arbiter_pkg.sv | 34 +++
 rtl/id_fifo.sv | 74 +++++++
 rtl/sram_bus_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter_pkg
//  Description : Shared types and constants for the sram-like bus arbiter:
//                command layout, requester IDs and lock FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bus_arbiter_pkg;

    // Total width of one sram-like command word.
    localparam int c_SRAM_CMD_W = 71;

    // Command layout, MSB first: {wr, size, wstrb, addr, wdata}.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    // Requester IDs as stored in the in-order ID FIFO.
    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    // Address-phase lock: once a request is presented and not yet accepted,
    // the grant is frozen on its owner so the command cannot change under it.
    typedef enum logic [0:0] {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

endpackage : sram_bus_arbiter_pkg
`default_nettype wire

// File: rtl/id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : id_fifo
//  Description : In-order FIFO of 1-bit requester IDs for requests accepted
//                downstream and still awaiting their data_ok.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_fifo
    import sram_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic full,
    output logic empty
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    logic [DEPTH-1:0] r_mem;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Status comes from the registered count, so a same-cycle pop never frees
    // a slot for a push until the following cycle.
    always_comb begin
        full      = (r_count == c_FULL_CNT);
        empty     = (r_count == '0);
        head_id   = r_mem[r_rd_ptr];
        w_do_push = push & ~full;
        w_do_pop  = pop & ~empty;
    end

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : id_fifo
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Two-to-one sram-like bus arbiter (instruction side m0, data
//                side m1) with address-phase locking, m0 anti-starvation and
//                in-order routing of responses via an ID FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    // Requester 0: instruction side
    input  logic                    m0_req,
    input  logic [c_SRAM_CMD_W-1:0] m0_cmd,
    output logic                    m0_addr_ok,
    output logic                    m0_data_ok,
    output logic [31:0]             m0_rdata,
    // Requester 1: data side
    input  logic                    m1_req,
    input  logic [c_SRAM_CMD_W-1:0] m1_cmd,
    output logic                    m1_addr_ok,
    output logic                    m1_data_ok,
    output logic [31:0]             m1_rdata,
    // Downstream sram-like port
    output logic                    s_req,
    output logic [c_SRAM_CMD_W-1:0] s_cmd,
    input  logic                    s_addr_ok,
    input  logic                    s_data_ok,
    input  logic [31:0]             s_rdata
);

    localparam int                  c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

    lock_state_t             r_state;
    lock_state_t             w_state_nxt;
    logic                    r_owner;
    logic                    w_owner_nxt;
    logic                    w_grant;
    logic                    w_grant_req;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_head;
    logic [c_STARVE_W-1:0]   r_starve_cnt;
    logic [31:0]             r_m0_rdata;
    logic [31:0]             r_m1_rdata;

    // Grant selection: locked owner first, then a starved m0, else m1 priority.
    always_comb begin
        w_grant = REQ_INST;
        if (r_state == LOCK_HELD) begin
            w_grant = r_owner;
        end else if ((r_starve_cnt == c_STARVE_MAX) && m0_req) begin
            w_grant = REQ_INST;
        end else if (m1_req) begin
            w_grant = REQ_DATA;
        end
        w_grant_req = (w_grant == REQ_DATA) ? m1_req : m0_req;
    end

    // Zero-latency address path plus handshake, push/pop and response routing.
    always_comb begin
        s_req      = resetn & w_grant_req & ~w_fifo_full;
        s_cmd      = (w_grant == REQ_DATA) ? m1_cmd : m0_cmd;
        w_push     = s_req & s_addr_ok;
        m0_addr_ok = w_push & (w_grant == REQ_INST);
        m1_addr_ok = w_push & (w_grant == REQ_DATA);
        // Responses with nothing outstanding are silently dropped.
        w_pop      = resetn & s_data_ok & ~w_fifo_empty;
        m0_data_ok = w_pop & (w_fifo_head == REQ_INST);
        m1_data_ok = w_pop & (w_fifo_head == REQ_DATA);
        m0_rdata   = m0_data_ok ? s_rdata : r_m0_rdata;
        m1_rdata   = m1_data_ok ? s_rdata : r_m1_rdata;
    end

    // Lock next-state: freeze on a presented-but-unaccepted request.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            LOCK_IDLE: begin
                if (s_req && !s_addr_ok) begin
                    w_state_nxt = LOCK_HELD;
                    w_owner_nxt = w_grant;
                end
            end
            LOCK_HELD: begin
                // While held, w_grant_req is the owner's own request.
                if (s_addr_ok || !w_grant_req) begin
                    w_state_nxt = LOCK_IDLE;
                end
            end
            default: begin
                w_state_nxt = LOCK_IDLE;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= LOCK_IDLE;
            r_owner <= REQ_INST;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Count consecutive m1 wins over a waiting m0, saturating at the limit.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (!m0_req || m0_addr_ok) begin
            r_starve_cnt <= '0;
        end else if (m1_addr_ok && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
        end
    end

    // Hold the last delivered read data per requester between responses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (m0_data_ok) begin
                r_m0_rdata <= s_rdata;
            end
            if (m1_data_ok) begin
                r_m1_rdata <= s_rdata;
            end
        end
    end

    id_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (w_push),
        .push_id (w_grant),
        .pop     (w_pop),
        .head_id (w_fifo_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

endmodule : sram_bus_arbiter
`default_nettype wire
